// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - register-file write-port scheduler with init sequencing and starvation stall
module regfile_write_sched #(
    parameter logic [3:0]  SP_REG       = 4'hF,
    parameter logic [15:0] SP_INIT      = 16'hFFFF,
    parameter bit          INIT_CLEAR   = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [3:0]  wb_reg,
    input  logic [15:0] wb_data,
    input  logic        sp_req,
    input  logic [15:0] sp_data,
    output logic        sp_ack,
    input  logic        cfg_req,
    input  logic [3:0]  cfg_reg,
    input  logic [15:0] cfg_data,
    output logic        cfg_ack,
    output logic        RegWrite,
    output logic [3:0]  WriteReg,
    output logic [15:0] WriteData,
    output logic        init_busy,
    output logic        stall_req
);

    localparam logic [1:0] ST_INIT_CLR = 2'd0;
    localparam logic [1:0] ST_INIT_SP  = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    // Without the clear phase, reset lands directly on the SP load.
    localparam logic [1:0] ST_START    = INIT_CLEAR ? ST_INIT_CLR : ST_INIT_SP;

    localparam logic [3:0] CLR_LAST = 4'd14;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    // last_lo encoding: which low-priority requester was granted most recently
    localparam logic LAST_SP  = 1'b0;
    localparam logic LAST_CFG = 1'b1;

    logic [1:0] state_q, state_d;
    logic [3:0] clr_idx_q, clr_idx_d;
    logic       last_lo_q, last_lo_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       stall_req_q, stall_req_d;

    logic gnt_sp;
    logic gnt_cfg;

    // Write-port mux and arbitration; everything is forced idle while reset is held.
    always_comb begin
        gnt_sp    = 1'b0;
        gnt_cfg   = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = 4'd0;
        WriteData = 16'd0;
        init_busy = 1'b1;
        if (rst) begin
            case (state_q)
                ST_INIT_CLR: begin
                    RegWrite = 1'b1;
                    WriteReg = clr_idx_q;
                end
                ST_INIT_SP: begin
                    RegWrite  = 1'b1;
                    WriteReg  = SP_REG;
                    WriteData = SP_INIT;
                end
                ST_RUN: begin
                    init_busy = 1'b0;
                    if (wb_we) begin
                        RegWrite  = 1'b1;
                        WriteReg  = wb_reg;
                        WriteData = wb_data;
                    end else begin
                        if (sp_req && cfg_req) begin
                            gnt_sp  = (last_lo_q == LAST_CFG);
                            gnt_cfg = (last_lo_q == LAST_SP);
                        end else begin
                            gnt_sp  = sp_req;
                            gnt_cfg = cfg_req;
                        end
                        if (gnt_sp) begin
                            RegWrite  = 1'b1;
                            WriteReg  = SP_REG;
                            WriteData = sp_data;
                        end else if (gnt_cfg) begin
                            RegWrite  = 1'b1;
                            WriteReg  = cfg_reg;
                            WriteData = cfg_data;
                        end
                    end
                end
                default: begin
                    RegWrite = 1'b0;
                end
            endcase
        end
    end

    assign sp_ack    = gnt_sp;
    assign cfg_ack   = gnt_cfg;
    assign stall_req = stall_req_q;

    // Next-state for the init sequencer, round-robin pointer and starvation tracking.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        last_lo_d    = last_lo_q;
        starve_cnt_d = starve_cnt_q;
        stall_req_d  = stall_req_q;

        case (state_q)
            ST_INIT_CLR: begin
                if (clr_idx_q == CLR_LAST) begin
                    clr_idx_d = 4'd0;
                    state_d   = ST_INIT_SP;
                end else begin
                    clr_idx_d = clr_idx_q + 4'd1;
                end
            end
            ST_INIT_SP: state_d = ST_RUN;
            ST_RUN:     state_d = ST_RUN;
            default:    state_d = ST_START;
        endcase

        if (gnt_sp) begin
            last_lo_d = LAST_SP;
        end else if (gnt_cfg) begin
            last_lo_d = LAST_CFG;
        end

        if (gnt_sp || gnt_cfg || !(sp_req || cfg_req)) begin
            starve_cnt_d = 4'd0;
        end else if ((state_q == ST_RUN) && wb_we && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // A served low-priority write releases the bubble; otherwise it latches on reaching the limit.
        if (gnt_sp || gnt_cfg) begin
            stall_req_d = 1'b0;
        end else if (starve_cnt_d == LIMIT) begin
            stall_req_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_START;
            clr_idx_q    <= 4'd0;
            last_lo_q    <= LAST_CFG;
            starve_cnt_q <= 4'd0;
            stall_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            last_lo_q    <= last_lo_d;
            starve_cnt_q <= starve_cnt_d;
            stall_req_q  <= stall_req_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// tb/tb_regfile_write_sched.sv - scoreboard bench for regfile_write_sched
module tb_regfile_write_sched;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] data;
        logic        sp_ack;
        logic        cfg_ack;
        logic        busy;
        logic        stall;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst2 = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_reg = 4'd0;
    logic [15:0] wb_data = 16'd0;
    logic        sp_req = 1'b0;
    logic [15:0] sp_data = 16'd0;
    logic        cfg_req = 1'b0;
    logic [3:0]  cfg_reg = 4'd0;
    logic [15:0] cfg_data = 16'd0;

    logic        sp_ack, cfg_ack, RegWrite, init_busy, stall_req;
    logic [3:0]  WriteReg;
    logic [15:0] WriteData;
    logic        sp_ack2, cfg_ack2, RegWrite2, init_busy2, stall_req2;
    logic [3:0]  WriteReg2;
    logic [15:0] WriteData2;

    int n_cmp = 0;
    int n_bad = 0;
    wr_t q1[$];
    wr_t q2[$];

    regfile_write_sched dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .sp_req(sp_req), .sp_data(sp_data), .sp_ack(sp_ack),
        .cfg_req(cfg_req), .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .init_busy(init_busy), .stall_req(stall_req)
    );

    regfile_write_sched #(.INIT_CLEAR(1'b0), .SP_INIT(16'h7FFF)) dut2 (
        .clk(clk), .rst(rst2),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .sp_req(sp_req), .sp_data(sp_data), .sp_ack(sp_ack2),
        .cfg_req(cfg_req), .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_ack(cfg_ack2),
        .RegWrite(RegWrite2), .WriteReg(WriteReg2), .WriteData(WriteData2),
        .init_busy(init_busy2), .stall_req(stall_req2)
    );

    always #5 clk = ~clk;

    function automatic wr_t mk(input logic [3:0] i, input logic [15:0] d, input logic s,
                               input logic c, input logic b, input logic st);
        mk = {i, d, s, c, b, st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the INIT_CLEAR=1 instance
    always @(negedge clk) begin
        wr_t obs, exp;
        obs = mk(WriteReg, WriteData, sp_ack, cfg_ack, init_busy, stall_req);
        if (RegWrite) begin
            if (q1.size() == 0) flag("dut1 unexpected write");
            else begin
                exp = q1.pop_front();
                check("dut1 write", {8'h0, obs}, {8'h0, exp});
            end
        end else if (sp_ack || cfg_ack) begin
            flag("dut1 ack without write");
        end
    end

    // Monitor for the INIT_CLEAR=0 instance
    always @(negedge clk) begin
        wr_t obs, exp;
        obs = mk(WriteReg2, WriteData2, sp_ack2, cfg_ack2, init_busy2, stall_req2);
        if (RegWrite2) begin
            if (q2.size() == 0) flag("dut2 unexpected write");
            else begin
                exp = q2.pop_front();
                check("dut2 write", {8'h0, obs}, {8'h0, exp});
            end
        end else if (sp_ack2 || cfg_ack2) begin
            flag("dut2 ack without write");
        end
    end

    initial begin
        // Reset state with every requester active
        wb_we = 1'b1; sp_req = 1'b1; cfg_req = 1'b1;
        step(); step();
        check("rst RegWrite", 32'(RegWrite), 32'd0);
        check("rst WriteReg", 32'(WriteReg), 32'd0);
        check("rst WriteData", 32'(WriteData), 32'd0);
        check("rst acks", {30'd0, sp_ack, cfg_ack}, 32'd0);
        check("rst init_busy", 32'(init_busy), 32'd1);
        check("rst stall_req", 32'(stall_req), 32'd0);
        check("rst2 RegWrite", 32'(RegWrite2), 32'd0);
        check("rst2 init_busy", 32'(init_busy2), 32'd1);
        sp_req = 1'b0; cfg_req = 1'b0;

        // Init sequence; wb pulses must be ignored
        rst = 1'b1;
        wb_reg = 4'd7; wb_data = 16'hBEEF;
        for (int i = 0; i < 15; i++) begin
            wb_we = i[0];
            q1.push_back(mk(4'(i), 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
            step();
        end
        wb_we = 1'b1;
        q1.push_back(mk(4'hF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0));
        step();
        wb_we = 1'b0;
        #1;
        check("run init_busy", 32'(init_busy), 32'd0);
        check("run idle RegWrite", 32'(RegWrite), 32'd0);
        step();

        // Round-robin: sp wins the first tie after reset
        sp_req = 1'b1; sp_data = 16'h1111;
        cfg_req = 1'b1; cfg_reg = 4'd9; cfg_data = 16'h0A0A;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) q1.push_back(mk(4'hF, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0));
            else            q1.push_back(mk(4'h9, 16'h0A0A, 1'b0, 1'b1, 1'b0, 1'b0));
            step();
        end
        sp_req = 1'b0; cfg_req = 1'b0;
        step();

        // Collision: wb first, sp the following cycle
        wb_we = 1'b1; wb_reg = 4'd3; wb_data = 16'h1234;
        sp_req = 1'b1; sp_data = 16'hFFFE;
        q1.push_back(mk(4'h3, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        wb_we = 1'b0;
        q1.push_back(mk(4'hF, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0));
        step();
        sp_req = 1'b0;
        step();

        // Starvation: cfg held behind continuous wb writes
        cfg_req = 1'b1; cfg_reg = 4'd5; cfg_data = 16'h00AA;
        for (int i = 1; i <= 5; i++) begin
            wb_we = 1'b1; wb_reg = 4'(i); wb_data = 16'h0100 + 16'(i);
            q1.push_back(mk(4'(i), 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0, (i == 5)));
            step();
        end
        wb_we = 1'b0;
        q1.push_back(mk(4'h5, 16'h00AA, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        cfg_req = 1'b0;
        #1;
        check("stall released", 32'(stall_req), 32'd0);
        step();

        // Mid-operation reset with sp pending behind wb
        wb_we = 1'b1; wb_reg = 4'd6; wb_data = 16'h6666;
        sp_req = 1'b1; sp_data = 16'h2222;
        q1.push_back(mk(4'h6, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        rst = 1'b0;
        #1;
        check("midrst RegWrite", 32'(RegWrite), 32'd0);
        check("midrst sp_ack", 32'(sp_ack), 32'd0);
        check("midrst init_busy", 32'(init_busy), 32'd1);
        wb_we = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            q1.push_back(mk(4'(i), 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
            step();
        end
        q1.push_back(mk(4'hF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0));
        step();
        q1.push_back(mk(4'hF, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0));
        step();
        sp_req = 1'b0;
        step();

        // INIT_CLEAR=0 instance: single SP write then RUN
        rst = 1'b0;
        step();
        rst2 = 1'b1;
        q2.push_back(mk(4'hF, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0));
        step();
        wb_we = 1'b1; wb_reg = 4'd0; wb_data = 16'h0001;
        q2.push_back(mk(4'h0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        wb_we = 1'b0;
        #1;
        check("dut2 idle RegWrite", 32'(RegWrite2), 32'd0);
        check("dut2 init_busy", 32'(init_busy2), 32'd0);
        step();

        check("dut1 leftover writes", 32'(q1.size()), 32'd0);
        check("dut2 leftover writes", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 16-entry, 16-bit register file in the decode stage. After reset it sequences register-file initialisation: R0–R14 are cleared and the stack pointer is loaded. It then shares the single write port between three requesters: pipeline writeback, stack-pointer updates from call/ret, and a debug/config write channel. When a low-priority requester is starved, the block raises a stall request to the hazard logic.

## Interface
- SP_REG, 4'hF: register index of the stack pointer
- SP_INIT, 16'hFFFF: value written to SP_REG at the end of init
- INIT_CLEAR, 1: 1 = clear R0..R14 to 0 before the SP load; 0 = SP load only
- STARVE_LIMIT, 4: consecutive lost arbitrations before stall_req asserts (legal range 1..15)

- clk  in  1  global clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- wb_we  in  1  writeback write request; never back-pressured in RUN
- wb_reg  in  4  writeback destination register
- wb_data  in  16  writeback data
- sp_req  in  1  SP update request; held until sp_ack
- sp_data  in  16  new SP value
- sp_ack  out  1  SP write performed this cycle
- cfg_req  in  1  debug write request; held until cfg_ack
- cfg_reg  in  4  debug write destination
- cfg_data  in  16  debug write data
- cfg_ack  out  1  debug write performed this cycle
- RegWrite  out  1  register-file write enable
- WriteReg  out  4  register-file write index
- WriteData  out  16  register-file write data
- init_busy  out  1  init in progress; the pipeline must hold
- stall_req  out  1  registered; requests a one-or-more-cycle pipeline bubble so the port frees up

## Operation
- State machine: INIT_CLR → INIT_SP → RUN. When INIT_CLEAR=0, reset enters INIT_SP directly.
- INIT_CLR:
  - A 4-bit counter clr_idx starts at 0.
  - Each cycle drives RegWrite=1, WriteReg=clr_idx, WriteData=0.
  - After clr_idx=14 the state moves to INIT_SP.
- INIT_SP: one cycle, RegWrite=1, WriteReg=SP_REG, WriteData=SP_INIT. Next state is RUN.
- In both init states:
  - wb_we is ignored.
  - sp_ack=0 and cfg_ack=0.
  - init_busy=1.
- RUN (init_busy=0) uses fixed priority, with wb highest:
  - If wb_we=1: write wb_reg/wb_data. No ack is issued to the other requesters.
  - Else, sp and cfg arbitrate round-robin. A last_lo flag records which of the two was granted most recently. When both are pending, the one not granted last wins. On reset last_lo = cfg, so sp wins the first tie.
  - The granted requester's ack is high in the same cycle its write is on the port. Ack is combinational.
  - sp writes go to index SP_REG with data sp_data.
- Write-port outputs are combinational from state and inputs. When no write is selected: RegWrite=0, WriteReg=0, WriteData=0.
- Starvation counter starve_cnt (4 bits):
  - Increments when in RUN, (sp_req|cfg_req)=1 and wb_we=1.
  - Clears on any sp_ack or cfg_ack, or when no low-priority request is pending.
  - Saturates at STARVE_LIMIT.
  - stall_req is a register. It is set the cycle after starve_cnt reaches STARVE_LIMIT and cleared the cycle after the next sp_ack/cfg_ack.
- No ordering or hazard check between requesters. When wb and sp target SP_REG in the same cycle, the wb write happens and the sp write follows later. The last write wins in the register file.

## Timing
- While rst=0:
  - State is INIT_CLR (or INIT_SP when INIT_CLEAR=0), clr_idx=0, starve_cnt=0, last_lo=cfg.
  - Outputs: stall_req=0, RegWrite=0 (forced), sp_ack=0, cfg_ack=0, init_busy=1, WriteReg=0, WriteData=0.
- Init length after rst rises, with INIT_CLEAR=1:
  - Edges 0..14 commit R0..R14 = 0.
  - Edge 15 commits SP.
  - init_busy falls after edge 15, so the 17th cycle is in RUN.
- Init length with INIT_CLEAR=0: one SP write, then RUN.
- A reset asserted mid-init or mid-RUN immediately forces RegWrite=0 and restarts init from the beginning. Pending requests are dropped, and requesters must re-hold req.
- Ack latency: 0 cycles from the cycle the request wins arbitration. Minimum sp/cfg latency is 0 when wb is idle.
- stall_req is asserted 1 cycle after starve_cnt reaches STARVE_LIMIT.

## Test plan
- Reset/init, INIT_CLEAR=1:
  - Release rst → R0..R14 written 0 on 15 consecutive cycles, then R15=FFFF on the 16th.
  - init_busy high for 16 cycles after release.
  - wb_we pulses during init produce no write.
- Collision: in RUN, wb_we=1 (R3=1234) with sp_req=1 (sp_data=FFFE) → cycle 1 writes R3=1234 with sp_ack=0; cycle 2 writes R15=FFFE with sp_ack=1.
- Round-robin:
  - sp_req and cfg_req held, wb idle → grants sp, cfg, sp, cfg on successive cycles.
  - Each ack aligns with RegWrite and the correct WriteReg/WriteData.
- Starvation: cfg_req held (R5=00AA) with wb_we=1 every cycle, STARVE_LIMIT=4:
  - stall_req rises 1 cycle after the 4th loss.
  - When the bench drops wb_we → cfg_ack the same cycle, R5=00AA written, stall_req falls next cycle.
- Mid-operation reset: assert rst while sp_req is pending in RUN → RegWrite=0 immediately, no sp_ack. On release, the full init sequence replays before sp is granted.
- INIT_CLEAR=0, SP_INIT=16'h7FFF: release rst → a single write of R15=7FFF, init_busy high for one cycle, then a wb write of R0=0001 is accepted the next cycle.
